// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down counter with programmable modulus, parallel load, clear, wrap/saturate and wrap pulse.
// Define COUNTER_PRESCALE_EN to allow a count step only once every PRESCALE enabled cycles.
module counter_updown_mod #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0,
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) || PRESCALE < 1)
    begin : g_bad_cfg
        $error("counter_updown_mod: illegal parameter combination");
    end

    logic             tick;
    logic             step;
    logic             at_end;
    logic             at_end_seen;
    logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
    localparam int          PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

    logic [PW-1:0] psc;

    assign tick = enable && (psc == PTOP);

    // Prescaler only advances on enabled cycles; clear/load restart the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            psc <= '0;
        else if (clear || load)
            psc <= '0;
        else if (enable)
            psc <= tick ? '0 : psc + PW'(1);
    end
`else
    assign tick = enable;
`endif

    assign load_clamped = (64'(load_value) > 64'(TOP)) ? TOP : load_value;
    assign step         = tick && !clear && !load;
    assign at_end       = up_down ? (count == TOP) : (count == '0);
    assign tc           = step && at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            wrap        <= 1'b0;
            at_end_seen <= 1'b0;
        end else if (clear) begin
            count       <= '0;
            wrap        <= 1'b0;
            at_end_seen <= 1'b0;
        end else if (load) begin
            count       <= load_clamped;
            wrap        <= 1'b0;
            at_end_seen <= 1'b0;
        end else if (step) begin
            if (!at_end) begin
                count       <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
                wrap        <= 1'b0;
                at_end_seen <= 1'b0;
            end else if (SATURATE) begin
                // Pulse only on the first blocked step; later attempts at the end stay quiet.
                wrap        <= !at_end_seen;
                at_end_seen <= 1'b1;
            end else begin
                count <= up_down ? '0 : TOP;
                wrap  <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_updown_mod.sv
// Randomized bench for counter_updown_mod: wrap and saturate instances share stimulus
// and are compared against an integer reference model each cycle.
module tb_counter_updown_mod;
    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int PS  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable, up_down, load, clear;
    logic [W-1:0] load_value;
    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, wrap_w, wrap_s;

    int checks   = 0;
    int failures = 0;

    // reference state: index 0 = wrap instance, 1 = saturate instance
    int m_cnt[2];
    int m_wrap[2];
    int m_hold[2];
    int m_psc;

    counter_updown_mod #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1'b0), .PRESCALE(PS)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .count(count_w), .tc(tc_w), .wrap(wrap_w)
    );

    counter_updown_mod #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1'b1), .PRESCALE(PS)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .count(count_s), .tc(tc_s), .wrap(wrap_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_step();
`ifdef COUNTER_PRESCALE_EN
        return enable && (m_psc == PS - 1) && !clear && !load;
`else
        return enable && !clear && !load;
`endif
    endfunction

    function automatic int exp_tc(input int d);
        if (!m_step()) return 0;
        return (up_down ? (m_cnt[d] == MOD - 1) : (m_cnt[d] == 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_wrap[d] = 0;
            m_hold[d] = 0;
        end
        m_psc = 0;
    endtask

    task automatic model_update();
        bit st;
        st = m_step();
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                m_cnt[d] = 0; m_wrap[d] = 0; m_hold[d] = 0;
            end else if (load) begin
                m_cnt[d]  = (int'(load_value) >= MOD) ? MOD - 1 : int'(load_value);
                m_wrap[d] = 0; m_hold[d] = 0;
            end else if (st) begin
                int nxt;
                nxt = up_down ? m_cnt[d] + 1 : m_cnt[d] - 1;
                if (nxt >= 0 && nxt < MOD) begin
                    m_cnt[d] = nxt; m_wrap[d] = 0; m_hold[d] = 0;
                end else if (d == 1) begin
                    m_hold[d]++;
                    m_wrap[d] = (m_hold[d] == 1) ? 1 : 0;
                end else begin
                    m_cnt[d]  = (nxt + MOD) % MOD;
                    m_wrap[d] = 1;
                end
            end else begin
                m_wrap[d] = 0;
            end
        end
`ifdef COUNTER_PRESCALE_EN
        if (clear || load)
            m_psc = 0;
        else if (enable)
            m_psc = (m_psc + 1) % PS;
`endif
    endtask

    task automatic drive(input bit en, input bit ud, input bit ld, input int lv, input bit clr);
        enable     = en;
        up_down    = ud;
        load       = ld;
        load_value = W'(lv);
        clear      = clr;
    endtask

    // called just after a posedge; checks tc before the edge, state after it
    task automatic cycle();
        #1;
        check("tc_wrap", tc_w, exp_tc(0));
        check("tc_sat",  tc_s, exp_tc(1));
        @(posedge clk);
        model_update();
        #1;
        check("count_wrap", count_w, m_cnt[0]);
        check("wrap_wrap",  wrap_w,  m_wrap[0]);
        check("count_sat",  count_s, m_cnt[1]);
        check("wrap_sat",   wrap_s,  m_wrap[1]);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_count_wrap", count_w, 0);
        check("rst_async_wrap_wrap",  wrap_w,  0);
        check("rst_async_count_sat",  count_s, 0);
        check("rst_async_wrap_sat",   wrap_s,  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit ud_r;
        rst = 1'b1;
        drive(0, 1, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_count_wrap", count_w, 0);
        check("reset_wrap_wrap",  wrap_w,  0);
        check("reset_count_sat",  count_s, 0);
        check("reset_tc_wrap",    tc_w,    0);
        rst = 1'b0;

        // count up through the modulus boundary
        drive(1, 1, 0, 0, 0);
        repeat (12) cycle();
`ifndef COUNTER_PRESCALE_EN
        check("plan_up_end", count_w, 2);
`endif

        // load 3, count down through 0, then clamp an out-of-range load
        drive(1, 0, 1, 3, 0);
        cycle();
        drive(1, 0, 0, 0, 0);
        repeat (5) cycle();
        drive(0, 0, 1, 15, 0);
        cycle();
        check("load_clamp", count_w, 9);

        // saturate from 7 upward, then reverse
        drive(0, 1, 1, 7, 0);
        cycle();
        drive(1, 1, 0, 0, 0);
        repeat (5) cycle();
        drive(1, 0, 0, 0, 0);
        repeat (2) cycle();

        // clear beats load beats step; then idle
        drive(0, 1, 1, 5, 0);
        cycle();
        drive(1, 1, 1, 7, 1);
        cycle();
        check("clear_priority", count_s, 0);
        drive(0, 1, 0, 0, 0);
        repeat (3) cycle();

        // async reset mid-count, then resume
        drive(0, 1, 1, 6, 0);
        cycle();
        drive(1, 1, 0, 0, 0);
        mid_reset();
        repeat (3) cycle();

        // enable gaps mid-period
        drive(0, 1, 0, 0, 1);
        cycle();
        drive(1, 1, 0, 0, 0);
        repeat (6) cycle();
        drive(0, 1, 0, 0, 0);
        repeat (2) cycle();
        drive(1, 1, 0, 0, 0);
        repeat (6) cycle();

        // random traffic with sticky direction so ends are reached often
        ud_r = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) ud_r = ~ud_r;
            drive($urandom_range(0, 3) != 0, ud_r, $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) mid_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
